// File: rtl/modmapper_sipo.sv
// Uplink TX modulation mapper: gathers Qm serial scrambled bits per symbol and
// emits one registered signed I/Q sample per symbol (QPSK or 16-QAM).
module modmapper_sipo #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 12,
    parameter int AMP_QPSK   = 5793,
    parameter int AMP_QAM_LO = 2591,
    parameter int AMP_QAM_HI = 7772
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_Qm,
    input  logic [LEN_WIDTH-1:0]  i_n_sym,
    input  logic                  i_din,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_I,
    output logic [DATA_WIDTH-1:0] o_Q,
    output logic                  o_valid,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam logic signed [DATA_WIDTH-1:0] AMP_Q  = DATA_WIDTH'(AMP_QPSK);
    localparam logic signed [DATA_WIDTH-1:0] AMP_LO = DATA_WIDTH'(AMP_QAM_LO);
    localparam logic signed [DATA_WIDTH-1:0] AMP_HI = DATA_WIDTH'(AMP_QAM_HI);

    logic [0:0]           state;
    logic                 qam_r;      // 1: 16-QAM (4 bits/symbol), 0: QPSK
    logic [LEN_WIDTH-1:0] n_sym_r;
    logic [LEN_WIDTH-1:0] sym_cnt;
    logic [1:0]           bit_cnt;
    logic [3:0]           bits_r;

    logic                        qm_legal;
    logic                        last_bit;
    logic                        last_sym;
    logic [3:0]                  bits_next;
    logic signed [DATA_WIDTH-1:0] mag_i;
    logic signed [DATA_WIDTH-1:0] mag_q;
    logic signed [DATA_WIDTH-1:0] map_i;
    logic signed [DATA_WIDTH-1:0] map_q;

    assign qm_legal = (i_Qm == 3'd2) || (i_Qm == 3'd4);
    assign last_bit = qam_r ? (bit_cnt == 2'd3) : (bit_cnt == 2'd1);
    assign last_sym = (sym_cnt == n_sym_r - LEN_WIDTH'(1));
    assign o_busy   = (state == ST_COLLECT);

    // The bit arriving this cycle completes the symbol, so map from the
    // register contents with that bit already merged in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bits_next          = bits_r;
        bits_next[bit_cnt] = i_din;

        if (qam_r) begin
            mag_i = bits_next[2] ? AMP_HI : AMP_LO;
            mag_q = bits_next[3] ? AMP_HI : AMP_LO;
        end else begin
            mag_i = AMP_Q;
            mag_q = AMP_Q;
        end

        map_i = bits_next[0] ? -mag_i : mag_i;
        map_q = bits_next[1] ? -mag_q : mag_q;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (i_rst) begin
            state   <= ST_IDLE;
            qam_r   <= 1'b0;
            n_sym_r <= '0;
            sym_cnt <= '0;
            bit_cnt <= '0;
            bits_r  <= '0;
            o_I     <= '0;
            o_Q     <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;

            if (i_start) begin
                // Any start aborts the running frame; partial symbol is dropped.
                sym_cnt <= '0;
                bit_cnt <= '0;
                if (!qm_legal) begin
                    state <= ST_IDLE;
                    o_err <= 1'b1;
                end else if (i_n_sym == '0) begin
                    state  <= ST_IDLE;
                    o_done <= 1'b1;
                end else begin
                    state   <= ST_COLLECT;
                    qam_r   <= (i_Qm == 3'd4);
                    n_sym_r <= i_n_sym;
                    if (i_valid) begin
                        bits_r[0] <= i_din;
                        bit_cnt   <= 2'd1;
                    end
                end
            end else if (state == ST_COLLECT && i_valid) begin
                bits_r[bit_cnt] <= i_din;
                if (last_bit) begin
                    o_I     <= map_i;
                    o_Q     <= map_q;
                    o_valid <= 1'b1;
                    bit_cnt <= '0;
                    sym_cnt <= sym_cnt + LEN_WIDTH'(1);
                    if (last_sym) begin
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_modmapper_sipo.sv
// Directed self-checking bench for modmapper_sipo: hand-computed I/Q vectors,
// frame control (done/err/abort/restart) and reset behaviour.
module tb_modmapper_sipo;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_Qm;
    logic [11:0] i_n_sym;
    logic        i_din;
    logic        i_valid;
    logic [15:0] o_I;
    logic [15:0] o_Q;
    logic        o_valid;
    logic        o_done;
    logic        o_busy;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int v0;
    int d0;
    int e0;

    modmapper_sipo dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_Qm    (i_Qm),
        .i_n_sym (i_n_sym),
        .i_din   (i_din),
        .i_valid (i_valid),
        .o_I     (o_I),
        .o_Q     (o_Q),
        .o_valid (o_valid),
        .o_done  (o_done),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_valid) valid_cnt++;
        if (o_done)  done_cnt++;
        if (o_err)   err_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input logic [2:0] qm, input logic [11:0] n);
        i_start = 1'b1;
        i_Qm    = qm;
        i_n_sym = n;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        i_valid = 1'b1;
        i_din   = b;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic snap();
        v0 = valid_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    function automatic int s_i();
        return int'($signed(o_I));
    endfunction

    function automatic int s_q();
        return int'($signed(o_Q));
    endfunction

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_Qm = 3'd2; i_n_sym = '0; i_din = 1'b0; i_valid = 1'b0;
        tick(); tick();
        check("rst_valid", o_valid, 0);
        check("rst_done",  o_done,  0);
        check("rst_busy",  o_busy,  0);
        check("rst_err",   o_err,   0);
        check("rst_I",     s_i(),   0);
        check("rst_Q",     s_q(),   0);
        i_rst = 1'b0;
        tick();

        // QPSK, two symbols: 0,1 then 1,0
        start(3'd2, 12'd2);
        check("qpsk_busy", o_busy, 1);
        send_bit(1'b0);
        check("qpsk_nv_mid", o_valid, 0);
        send_bit(1'b1);
        check("qpsk_v1",   o_valid, 1);
        check("qpsk_I1",   s_i(), 5793);
        check("qpsk_Q1",   s_q(), -5793);
        check("qpsk_d1",   o_done, 0);
        send_bit(1'b1);
        check("qpsk_v1_pulse", o_valid, 0);
        send_bit(1'b0);
        check("qpsk_v2",   o_valid, 1);
        check("qpsk_I2",   s_i(), -5793);
        check("qpsk_Q2",   s_q(), 5793);
        check("qpsk_d2",   o_done, 1);
        tick();
        check("qpsk_v_off", o_valid, 0);
        check("qpsk_d_off", o_done, 0);
        check("qpsk_idle",  o_busy, 0);
        check("qpsk_hold_I", s_i(), -5793);

        // 16-QAM, one symbol: 1,0,1,1
        start(3'd4, 12'd1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("qam_nv", o_valid, 0);
        send_bit(1'b1);
        check("qam_v",  o_valid, 1);
        check("qam_I",  s_i(), -7772);
        check("qam_Q",  s_q(), 7772);
        check("qam_d",  o_done, 1);
        tick();
        check("qam_idle", o_busy, 0);

        // 16-QAM with 3-cycle gaps: 0,1,0,0
        start(3'd4, 12'd1);
        snap();
        send_bit(1'b0); tick(); tick(); tick();
        send_bit(1'b1); tick(); tick(); tick();
        send_bit(1'b0); tick(); tick(); tick();
        check("gap_nv", valid_cnt - v0, 0);
        send_bit(1'b0);
        check("gap_v",  o_valid, 1);
        check("gap_I",  s_i(), 2591);
        check("gap_Q",  s_q(), -2591);
        tick();
        check("gap_count", valid_cnt - v0, 1);

        // Illegal Qm, then ignored bits
        snap();
        start(3'd6, 12'd1);
        check("err_pulse", o_err, 1);
        check("err_busy",  o_busy, 0);
        send_bit(1'b1);
        check("err_single", o_err, 0);
        send_bit(1'b1); tick();
        check("err_nv", valid_cnt - v0, 0);
        check("err_nd", done_cnt - d0, 0);
        check("err_cnt", err_cnt - e0, 1);

        // n_sym = 0: done only
        snap();
        start(3'd2, 12'd0);
        check("zero_done", o_done, 1);
        check("zero_busy", o_busy, 0);
        tick();
        check("zero_nv", valid_cnt - v0, 0);
        check("zero_ne", err_cnt - e0, 0);

        // Restart mid-frame: QPSK partial, then 16-QAM 0,0,1,0
        snap();
        start(3'd2, 12'd2);
        send_bit(1'b1);
        start(3'd4, 12'd1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("rs_nv", valid_cnt - v0, 0);
        send_bit(1'b0);
        check("rs_I", s_i(), 7772);
        check("rs_Q", s_q(), 2591);
        tick();
        check("rs_vcnt", valid_cnt - v0, 1);
        check("rs_dcnt", done_cnt - d0, 1);

        // Start with bit in same cycle; Qm change afterwards must not matter
        i_valid = 1'b1; i_din = 1'b1;
        start(3'd2, 12'd1);
        i_valid = 1'b0;
        i_Qm = 3'd4; i_n_sym = 12'd5;
        send_bit(1'b0);
        check("sv_v", o_valid, 1);
        check("sv_I", s_i(), -5793);
        check("sv_Q", s_q(), 5793);
        check("sv_d", o_done, 1);

        // Reset mid-frame, later bits ignored; reset beats start
        start(3'd4, 12'd1);
        send_bit(1'b1); send_bit(1'b1);
        i_rst = 1'b1;
        tick();
        check("mr_busy", o_busy, 0);
        check("mr_I", s_i(), 0);
        check("mr_Q", s_q(), 0);
        check("mr_valid", o_valid, 0);
        i_start = 1'b1; i_Qm = 3'd2; i_n_sym = 12'd1;
        tick();
        i_start = 1'b0;
        check("mr_dom", o_busy, 0);
        i_rst = 1'b0;
        snap();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); tick();
        check("mr_nv", valid_cnt - v0, 0);
        check("mr_nd", done_cnt - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
